fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch unit for the 32-bit CPU: the producer side of the `instr` interface consumed by the controller.
- Holds the program counter, reads one instruction word per fetch from instruction memory, and presents it with a valid/ready handshake.
- Redirects on taken jz/jg and stops permanently once the controller reports halt.
- Sits between instruction memory and the controller; `pc` feeds the controller's pc-store path.

## Interface
Parameters:
- N, 32, instruction width
- M, 16, word-address width
- RESET_PC, 0, first fetch address after reset

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset; one clock, reset is synchronous and active-high
- imem_req  out  1  fetch request, level, held until response
- imem_addr  out  M  word address of current request
- imem_rdata  in  N  fetched word, valid with imem_valid
- imem_valid  in  1  one-cycle response strobe
- instr  out  N  instruction to controller
- instr_valid  out  1  instr/pc hold a fetched instruction
- decode_ready  in  1  controller accepts instr this cycle
- pc  out  M  address instr was fetched from
- is_jz  in  1  controller: instr is jz
- is_jg  in  1  controller: instr is jg
- cond_zero  in  1  ALU zero flag for current instr
- cond_gt  in  1  ALU greater flag for current instr
- target  in  M  branch target for current instr
- is_halted  in  1  controller halted
- halted  out  1  fetch stopped

## Operation
- States:
  - IDLE: entered on reset, lasts 1 cycle.
  - FETCH: request outstanding.
  - HOLD: instruction presented.
  - HALT: terminal.
- Transitions:
  - IDLE -> FETCH unconditionally.
  - FETCH -> HOLD on edge with imem_valid=1.
  - HOLD -> FETCH on edge with decode_ready=1.
  - Any state -> HALT on edge with is_halted=1.
  - HALT -> IDLE only via rst.
- Priority: rst > is_halted > normal transitions.
- FETCH:
  - imem_req=1, imem_addr=fetch_pc.
  - On imem_valid: instr<=imem_rdata, pc<=fetch_pc.
- HOLD:
  - instr_valid=1; instr and pc stable; imem_req=0.
- Accept = HOLD && decode_ready. On the accept edge, sample is_jz, is_jg, cond_zero, cond_gt and target; they must be stable combinational functions of instr.
  - Taken = (is_jz && cond_zero) || (is_jg && cond_gt).
  - fetch_pc <= taken ? target : pc+1.
- Arithmetic: pc+1 is M-bit modulo, so 2^M-1 wraps to 0.
- imem_valid outside FETCH is ignored: in IDLE, HOLD, HALT or during rst.
- HALT:
  - imem_req=0, instr_valid=0, halted=1.
  - decode_ready and imem_valid ignored.
- Reset values: imem_req 0, imem_addr RESET_PC, instr 0, instr_valid 0, pc RESET_PC, halted 0, fetch_pc RESET_PC, state IDLE.
- Reset mid-fetch abandons the request. The memory must not deliver a response for a request issued before reset.

## Timing
- Outputs are decoded from registered state only; there is no combinational input-to-output path.
- First imem_req is asserted in the second cycle after rst deasserts, because IDLE lasts one cycle.
- imem_valid may assert in the first cycle of imem_req (zero-latency memory) or any later cycle.
- imem_req falls in the cycle after the imem_valid edge.
- instr_valid rises in the cycle after the imem_valid edge.
- Peak throughput: one instruction per 2 cycles with zero-latency memory and decode_ready tied high.
- Backpressure: while decode_ready=0 in HOLD, all outputs are frozen and no request is issued.
- Redirect penalty: none beyond normal fetch; the target is the next request address.
- is_halted seen on an edge forces halted=1 and imem_req=0 from the next cycle.

## Configuration
- FETCH_BRANCH_EN defined: jz/jg redirect as above.
- FETCH_BRANCH_EN undefined:
  - fetch_pc always advances to pc+1.
  - is_jz, is_jg, cond_zero, cond_gt and target are ignored; no branch logic is synthesized.

## Test plan
- Sequential fetch:
  - Stimulus: rst for 2 cycles; memory with 1-cycle latency holds Add words at 0..3; decode_ready=1.
  - Response: imem_addr sequence 0,1,2,3; each instr_valid pulse carries the matching word with pc 0,1,2,3; first imem_req 2 cycles after rst falls.
- Backpressure:
  - Stimulus: in HOLD at pc=2, decode_ready=0 for 3 cycles.
  - Response: instr, pc and instr_valid=1 stable, imem_req=0 throughout; next imem_addr=3 after decode_ready=1.
- Branch (FETCH_BRANCH_EN):
  - Taken: at pc=5, is_jz=1, cond_zero=1, target=0x0040 -> next imem_addr 0x0040.
  - Not taken: same with cond_zero=0 -> next imem_addr 6.
  - jg: is_jg=1, cond_gt=1, target=0x0010 -> next imem_addr 0x0010.
  - Without the macro: the taken-jz case gives next imem_addr 6.
- Wrap:
  - Stimulus: RESET_PC=16'hFFFF.
  - Response: fetches 0xFFFF then 0x0000.
- Halt:
  - Stimulus: is_halted=1 while in HOLD.
  - Response: next cycle halted=1, instr_valid=0; imem_req stays 0 for 10 cycles despite decode_ready=1 and spurious imem_valid.
  - Then rst: all outputs return to reset values and a new fetch from RESET_PC begins.
- Reset mid-fetch:
  - Stimulus: rst asserted while FETCH awaits a response; imem_valid pulses during rst.
  - Response: pulse ignored, instr=0, instr_valid=0; first post-reset request is to RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch FSM with valid/ready handoff; jz/jg redirect only when FETCH_BRANCH_EN is defined
module fetch_unit #(
    parameter int N = 32,
    parameter int M = 16,
    parameter logic [M-1:0] RESET_PC = '0
) (
    input  logic         clk,
    input  logic         rst,
    output logic         imem_req,
    output logic [M-1:0] imem_addr,
    input  logic [N-1:0] imem_rdata,
    input  logic         imem_valid,
    output logic [N-1:0] instr,
    output logic         instr_valid,
    input  logic         decode_ready,
    output logic [M-1:0] pc,
    input  logic         is_jz,
    input  logic         is_jg,
    input  logic         cond_zero,
    input  logic         cond_gt,
    input  logic [M-1:0] target,
    input  logic         is_halted,
    output logic         halted
);
    typedef enum logic [1:0] {IDLE, FETCH, HOLD, HALT} state_t;
    state_t state, state_next;
    logic [M-1:0] fetch_pc, next_pc;
    logic accept;
    assign accept = state == HOLD && decode_ready;
`ifdef FETCH_BRANCH_EN
    logic taken;
    assign taken = (is_jz && cond_zero) || (is_jg && cond_gt);
    assign next_pc = taken ? target : pc + M'(1);
`else
    logic unused;
    assign unused = ^{is_jz, is_jg, cond_zero, cond_gt, target};
    assign next_pc = pc + M'(1);
`endif
    always_comb begin
        state_next = state;
        if (is_halted) state_next = HALT;
        else if (state == IDLE) state_next = FETCH;
        else if (state == FETCH && imem_valid) state_next = HOLD;
        else if (accept) state_next = FETCH;
        imem_req = state == FETCH;
        instr_valid = state == HOLD;
        halted = state == HALT;
        imem_addr = fetch_pc;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            fetch_pc <= RESET_PC;
            pc <= RESET_PC;
            instr <= '0;
        end else begin
            state <= state_next;
            if (state == FETCH && imem_valid) begin
                instr <= imem_rdata;
                pc <= fetch_pc;
            end
            if (accept) fetch_pc <= next_pc;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and randomized checks of fetch_unit against a transaction-level program-counter model
module tb_fetch_unit;
    localparam int N = 32;
    localparam int M = 16;
    logic clk = 0;
    logic rst = 1;
    always #5 clk = ~clk;
    logic imem_req, imem_valid, instr_valid, halted;
    logic [M-1:0] imem_addr, pc;
    logic [N-1:0] imem_rdata, instr;
    logic decode_ready = 0, is_jz = 0, is_jg = 0, cond_zero = 0, cond_gt = 0, is_halted = 0;
    logic [M-1:0] target = '0;
    logic w_req, w_valid, w_instr_valid, w_halted;
    logic [M-1:0] w_addr, w_pc;
    logic [N-1:0] w_rdata, w_instr;
    int passed = 0;
    int total = 0;
    int lat = 1;
    int cnt = 0;
    logic spur = 0;

    function automatic logic [N-1:0] word(input logic [M-1:0] a);
        return {a ^ 16'h5A5A, ~a};
    endfunction

    // Memory: responds lat cycles after the request rises; spur injects a stray strobe.
    assign imem_valid = spur | (imem_req && cnt == lat);
    assign imem_rdata = word(imem_addr);
    always @(posedge clk) cnt <= (imem_req && !imem_valid) ? cnt + 1 : 0;
    assign w_valid = w_req;
    assign w_rdata = word(w_addr);

    fetch_unit dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .imem_valid(imem_valid), .instr(instr), .instr_valid(instr_valid), .decode_ready(decode_ready),
        .pc(pc), .is_jz(is_jz), .is_jg(is_jg), .cond_zero(cond_zero), .cond_gt(cond_gt),
        .target(target), .is_halted(is_halted), .halted(halted)
    );

    fetch_unit #(.RESET_PC(16'hFFFF)) dut_wrap (
        .clk(clk), .rst(rst), .imem_req(w_req), .imem_addr(w_addr), .imem_rdata(w_rdata),
        .imem_valid(w_valid), .instr(w_instr), .instr_valid(w_instr_valid), .decode_ready(decode_ready),
        .pc(w_pc), .is_jz(is_jz), .is_jg(is_jg), .cond_zero(cond_zero), .cond_gt(cond_gt),
        .target(target), .is_halted(is_halted), .halted(w_halted)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        {is_jz, is_jg, cond_zero, cond_gt, is_halted, spur} = '0;
        target = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1;
        repeat (2) step();
        rst = 0;
    endtask

    task automatic wait_req(input string name);
        bit ok = 0;
        for (int i = 0; i < 50 && !ok; i++) if (imem_req) ok = 1; else step();
        total++;
        if (!ok) $display("FAIL %s: imem_req never rose within 50 cycles", name); else passed++;
    endtask

    task automatic wait_valid(input string name);
        bit ok = 0;
        for (int i = 0; i < 50 && !ok; i++) if (instr_valid) ok = 1; else step();
        total++;
        if (!ok) $display("FAIL %s: instr_valid never rose within 50 cycles", name); else passed++;
    endtask

    task automatic goto_hold(input logic [M-1:0] a);
        bit ok = 0;
        do_reset();
        lat = 1;
        decode_ready = 1;
        for (int i = 0; i < 60 && !ok; i++) if (instr_valid && pc == a) ok = 1; else step();
        total++;
        if (!ok) $display("FAIL goto_hold: pc %h never presented", a); else passed++;
    endtask

    task automatic test_reset();
        rst = 1;
        repeat (2) step();
        total++;
        if ({imem_req, imem_addr, instr, instr_valid, pc, halted} !== {1'b0, 16'h0, 32'h0, 1'b0, 16'h0, 1'b0})
            $display("FAIL reset_values: req=%b addr=%h instr=%h iv=%b pc=%h halted=%b want all zero",
                     imem_req, imem_addr, instr, instr_valid, pc, halted);
        else passed++;
        rst = 0;
        total++;
        if (imem_req !== 1'b0) $display("FAIL first_req_early: imem_req=%b want 0", imem_req); else passed++;
        step();
        total++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0)
            $display("FAIL first_req: imem_req=%b addr=%h want 1/0000", imem_req, imem_addr);
        else passed++;
    endtask

    task automatic test_sequential();
        do_reset();
        lat = 1;
        decode_ready = 1;
        for (int i = 0; i < 4; i++) begin
            wait_req("seq_req");
            total++;
            if (imem_addr !== M'(i)) $display("FAIL seq_addr: got %h want %h", imem_addr, M'(i)); else passed++;
            wait_valid("seq_valid");
            total++;
            if (instr !== word(M'(i)) || pc !== M'(i))
                $display("FAIL seq_instr: instr=%h pc=%h want %h/%h", instr, pc, word(M'(i)), M'(i));
            else passed++;
            step();
        end
    endtask

    task automatic test_backpressure();
        goto_hold(2);
        decode_ready = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if ({instr_valid, imem_req, pc, instr} !== {1'b1, 1'b0, 16'h2, word(16'h2)})
                $display("FAIL backpressure_hold: iv=%b req=%b pc=%h instr=%h want 1/0/0002/%h",
                         instr_valid, imem_req, pc, instr, word(16'h2));
            else passed++;
        end
        decode_ready = 1;
        step();
        total++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h3)
            $display("FAIL backpressure_next: req=%b addr=%h want 1/0003", imem_req, imem_addr);
        else passed++;
    endtask

    task automatic branch_case(input string name, input logic jz, input logic jg, input logic cz,
                               input logic cg, input logic [M-1:0] tgt, input logic [M-1:0] exp);
        goto_hold(5);
        {is_jz, is_jg, cond_zero, cond_gt} = {jz, jg, cz, cg};
        target = tgt;
        step();
        clear_inputs();
        total++;
        if (imem_req !== 1'b1 || imem_addr !== exp)
            $display("FAIL %s: req=%b addr=%h want 1/%h", name, imem_req, imem_addr, exp);
        else passed++;
    endtask

    task automatic test_branch();
`ifdef FETCH_BRANCH_EN
        branch_case("jz_taken", 1, 0, 1, 0, 16'h0040, 16'h0040);
        branch_case("jg_taken", 0, 1, 0, 1, 16'h0010, 16'h0010);
`else
        branch_case("jz_ignored", 1, 0, 1, 0, 16'h0040, 16'h0006);
        branch_case("jg_ignored", 0, 1, 0, 1, 16'h0010, 16'h0006);
`endif
        branch_case("jz_not_taken", 1, 0, 0, 1, 16'h0040, 16'h0006);
    endtask

    task automatic test_wrap();
        do_reset();
        decode_ready = 1;
        step();
        total++;
        if (w_req !== 1'b1 || w_addr !== 16'hFFFF) $display("FAIL wrap_first: req=%b addr=%h want 1/ffff", w_req, w_addr); else passed++;
        step();
        total++;
        if (w_instr_valid !== 1'b1 || w_pc !== 16'hFFFF || w_instr !== word(16'hFFFF))
            $display("FAIL wrap_hold: iv=%b pc=%h instr=%h", w_instr_valid, w_pc, w_instr);
        else passed++;
        step();
        total++;
        if (w_req !== 1'b1 || w_addr !== 16'h0000) $display("FAIL wrap_next: req=%b addr=%h want 1/0000", w_req, w_addr); else passed++;
    endtask

    task automatic test_halt();
        goto_hold(1);
        is_halted = 1;
        step();
        is_halted = 0;
        total++;
        if ({halted, instr_valid, imem_req} !== 3'b100)
            $display("FAIL halt_enter: halted=%b iv=%b req=%b want 1/0/0", halted, instr_valid, imem_req);
        else passed++;
        for (int i = 0; i < 10; i++) begin
            spur = i[0];
            decode_ready = 1;
            step();
            total++;
            if ({halted, instr_valid, imem_req} !== 3'b100)
                $display("FAIL halt_stay: halted=%b iv=%b req=%b want 1/0/0", halted, instr_valid, imem_req);
            else passed++;
        end
        spur = 0;
        rst = 1;
        step();
        total++;
        if ({imem_req, imem_addr, instr, instr_valid, pc, halted} !== {1'b0, 16'h0, 32'h0, 1'b0, 16'h0, 1'b0})
            $display("FAIL halt_reset: req=%b addr=%h instr=%h iv=%b pc=%h halted=%b want all zero",
                     imem_req, imem_addr, instr, instr_valid, pc, halted);
        else passed++;
        rst = 0;
        step();
        total++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0) $display("FAIL halt_refetch: req=%b addr=%h want 1/0000", imem_req, imem_addr); else passed++;
    endtask

    task automatic test_reset_mid_fetch();
        do_reset();
        lat = 5;
        repeat (2) step();
        rst = 1;
        spur = 1;
        step();
        spur = 0;
        step();
        total++;
        if ({instr, instr_valid, imem_req} !== {32'h0, 1'b0, 1'b0})
            $display("FAIL mid_fetch_reset: instr=%h iv=%b req=%b want 0/0/0", instr, instr_valid, imem_req);
        else passed++;
        rst = 0;
        lat = 1;
        step();
        total++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0) $display("FAIL mid_fetch_refetch: req=%b addr=%h want 1/0000", imem_req, imem_addr); else passed++;
        wait_valid("mid_fetch_valid");
        total++;
        if (instr !== word(16'h0) || pc !== 16'h0) $display("FAIL mid_fetch_instr: instr=%h pc=%h", instr, pc); else passed++;
    endtask

    task automatic test_random();
        logic [M-1:0] cur = '0;
        logic tk;
        do_reset();
        decode_ready = 0;
        for (int n = 0; n < 40; n++) begin
            lat = $urandom_range(0, 3);
            wait_req("rand_req");
            total++;
            if (imem_addr !== cur) $display("FAIL rand_addr: got %h want %h", imem_addr, cur); else passed++;
            wait_valid("rand_valid");
            total++;
            if (instr !== word(cur) || pc !== cur) $display("FAIL rand_instr: instr=%h pc=%h want %h/%h", instr, pc, word(cur), cur); else passed++;
            {is_jz, is_jg, cond_zero, cond_gt} = 4'($urandom);
            target = M'($urandom);
            repeat ($urandom_range(0, 2)) begin
                step();
                total++;
                if (instr_valid !== 1'b1 || pc !== cur || imem_req !== 1'b0)
                    $display("FAIL rand_stall: iv=%b pc=%h req=%b want 1/%h/0", instr_valid, pc, imem_req, cur);
                else passed++;
            end
`ifdef FETCH_BRANCH_EN
            tk = (is_jz && cond_zero) || (is_jg && cond_gt);
`else
            tk = 0;
`endif
            cur = tk ? target : cur + 1'b1;
            decode_ready = 1;
            step();
            decode_ready = 0;
            clear_inputs();
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_backpressure();
        test_branch();
        test_wrap();
        test_halt();
        test_reset_mid_fetch();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
